mem_lsu: RTL and testbench

Memory stage of the RV32IM_Zicsr five-stage pipeline, between ex_mem and mem_wb. It runs load/store accesses on the data bus with a req/gnt/rvalid handshake, and byte- or sign-extends load data. It holds the pipeline through ctrl while an access is in flight and raises misaligned-access exceptions. Non-memory instructions pass straight through to mem_wb with no added latency.

---
 rtl/mem_lsu.sv | 250 +++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: pipeline memory stage - data bus access, load extension, misalignment traps.
// Defining LSU_BUS_TIMEOUT_EN adds the bus wait timeout counter and the FAULT state.
module mem_lsu #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_flush,
  input  logic             hold_i,
  input  logic             rd_we,
  input  logic [4:0]       rd_addr,
  input  logic [WIDTH-1:0] rd_wdata,
  input  logic             mem_re,
  input  logic             mem_we,
  input  logic [2:0]       mem_funct3,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_wdata,
  input  logic             csr_we,
  input  logic [11:0]      csr_waddr,
  input  logic [WIDTH-1:0] csr_wdata,
  output logic             rd_we_o,
  output logic [4:0]       rd_addr_o,
  output logic [WIDTH-1:0] rd_wdata_o,
  output logic             csr_we_o,
  output logic [11:0]      csr_waddr_o,
  output logic [WIDTH-1:0] csr_wdata_o,
  output logic             stall_req,
  output logic             dbus_req,
  output logic             dbus_we,
  output logic [WIDTH-1:0] dbus_addr,
  output logic [3:0]       dbus_be,
  output logic [WIDTH-1:0] dbus_wdata,
  input  logic             dbus_gnt,
  input  logic             dbus_rvalid,
  input  logic [WIDTH-1:0] dbus_rdata,
  output logic             exc_valid,
  output logic [3:0]       exc_cause,
  output logic [WIDTH-1:0] exc_tval,
  output logic [2:0]       state_dbg
);

  if (WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_lsu: WIDTH must be 32 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT_R = 3'd2,
    S_DONE   = 3'd3,
    S_DRAIN  = 3'd4
`ifdef LSU_BUS_TIMEOUT_EN
    , S_FAULT = 3'd5
`endif
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_e           state, state_next;
  logic             active;
  logic             capture;
  logic [WIDTH-1:0] load_q;
  logic             is_load, is_store, access, misaligned;
  logic [1:0]       size, lane;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic [WIDTH-1:0] load_ext, wdata_calc;
  logic [3:0]       be_calc;
  logic             timeout;

  assign is_load    = mem_re;
  assign is_store   = mem_we & ~mem_re;
  assign access     = mem_re | mem_we;
  assign lane       = mem_addr[1:0];
  assign size       = (mem_funct3[1:0] == 2'b00) ? SZ_B :
                      (mem_funct3[1:0] == 2'b01) ? SZ_H : SZ_W;
  assign misaligned = access & (((size == SZ_H) & mem_addr[0]) |
                                ((size == SZ_W) & (mem_addr[1:0] != 2'b00)));

  assign rbyte = dbus_rdata[{lane, 3'b000} +: 8];
  assign rhalf = mem_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

  // Unused funct3 codes (011, 110, 111) fall through to a full word.
  always_comb begin
    case (mem_funct3)
      3'b000:  load_ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_ext = {24'd0, rbyte};
      3'b101:  load_ext = {16'd0, rhalf};
      default: load_ext = dbus_rdata;
    endcase
  end

  always_comb begin
    case (size)
      SZ_B: begin
        be_calc    = 4'b0001 << lane;
        wdata_calc = {4{mem_wdata[7:0]}};
      end
      SZ_H: begin
        be_calc    = 4'b0011 << {mem_addr[1], 1'b0};
        wdata_calc = {2{mem_wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = mem_wdata;
      end
    endcase
  end

  // Outputs stay at zero until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      active <= 1'b0;
      load_q <= '0;
    end else begin
      state  <= state_next;
      active <= 1'b1;
      if (capture) load_q <= load_ext;
    end
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          fault_from_wait;

  assign timeout = ((state == S_REQ) || (state == S_WAIT_R)) &&
                   (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt          <= '0;
      fault_from_wait <= 1'b0;
    end else begin
      if (state_next != state) to_cnt <= '0;
      else if ((state == S_REQ) || (state == S_WAIT_R)) to_cnt <= to_cnt + 1'b1;
      if (state_next == S_FAULT) fault_from_wait <= (state == S_WAIT_R);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Bus handshake: dbus_req rises with the address/be/wdata and holds them until
  // dbus_gnt is seen high on a clock edge; a granted load returns exactly one
  // dbus_rvalid later. The request is withdrawn before grant only on ctrl_flush.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    stall_req   = 1'b0;
    dbus_req    = 1'b0;
    rd_we_o     = 1'b0;
    rd_addr_o   = '0;
    rd_wdata_o  = '0;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    exc_valid   = 1'b0;
    exc_cause   = 4'd0;
    exc_tval    = '0;
    if (active) begin
      rd_addr_o   = rd_addr;
      rd_wdata_o  = rd_wdata;
      csr_waddr_o = csr_waddr;
      csr_wdata_o = csr_wdata;
      case (state)
        S_IDLE: begin
          if (ctrl_flush) begin
            state_next = S_IDLE;
          end else if (!access) begin
            rd_we_o  = rd_we;
            csr_we_o = csr_we;
          end else if (misaligned) begin
            exc_valid = 1'b1;
            exc_cause = is_load ? 4'd4 : 4'd6;
            exc_tval  = mem_addr;
          end else begin
            dbus_req  = 1'b1;
            stall_req = 1'b1;
            if (dbus_gnt) state_next = is_load ? S_WAIT_R : S_DONE;
            else          state_next = S_REQ;
          end
        end
        S_REQ: begin
          dbus_req  = 1'b1;
          stall_req = 1'b1;
          if (dbus_gnt) begin
            if (is_load) state_next = ctrl_flush ? S_DRAIN : S_WAIT_R;
            else         state_next = ctrl_flush ? S_IDLE : S_DONE;
          end else if (ctrl_flush) begin
            state_next = S_IDLE;
          end else if (timeout) begin
`ifdef LSU_BUS_TIMEOUT_EN
            state_next = S_FAULT;
`endif
          end
        end
        S_WAIT_R: begin
          stall_req = 1'b1;
          if (ctrl_flush) begin
            state_next = dbus_rvalid ? S_IDLE : S_DRAIN;
          end else if (dbus_rvalid) begin
            capture    = 1'b1;
            state_next = S_DONE;
          end else if (timeout) begin
`ifdef LSU_BUS_TIMEOUT_EN
            state_next = S_FAULT;
`endif
          end
        end
        S_DONE: begin
          rd_we_o  = rd_we;
          csr_we_o = csr_we;
          if (is_load) rd_wdata_o = load_q;
          if (ctrl_flush || !hold_i) state_next = S_IDLE;
        end
        S_DRAIN: begin
          if (access) begin
            stall_req = 1'b1;
          end else begin
            rd_we_o  = rd_we;
            csr_we_o = csr_we;
          end
          if (dbus_rvalid) state_next = S_IDLE;
        end
`ifdef LSU_BUS_TIMEOUT_EN
        S_FAULT: begin
          exc_valid  = 1'b1;
          exc_cause  = is_load ? 4'd5 : 4'd7;
          exc_tval   = mem_addr;
          state_next = fault_from_wait ? S_DRAIN : S_IDLE;
        end
`endif
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign dbus_we    = dbus_req & is_store;
  assign dbus_addr  = dbus_req ? {mem_addr[WIDTH-1:2], 2'b00} : '0;
  assign dbus_be    = dbus_req ? be_calc : 4'd0;
  assign dbus_wdata = dbus_we ? wdata_calc : '0;
  assign state_dbg  = state;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu (default build, no bus timeout).
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        ctrl_flush, hold_i;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        mem_re, mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        stall_req, dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  mem_lsu #(.WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_flush(ctrl_flush), .hold_i(hold_i),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_req(stall_req), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, want bench to finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ctrl_flush = 0; hold_i = 0; rd_we = 0; rd_addr = '0; rd_wdata = '0;
    mem_re = 0; mem_we = 0; mem_funct3 = '0; mem_addr = '0; mem_wdata = '0;
    csr_we = 0; csr_waddr = '0; csr_wdata = '0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1;
    #2 rst_n = 0;
    mem_re = 1; mem_funct3 = 3'b010; mem_addr = 32'h100;
    rd_we = 1; rd_addr = 5'd1; rd_wdata = 32'h55; csr_we = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dbus_req !== 1'b0 || stall_req !== 1'b0 || exc_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: req=%0b stall=%0b exc=%0b want 0 0 0", dbus_req, stall_req, exc_valid);
    end
    checks++;
    if (rd_we_o !== 1'b0 || csr_we_o !== 1'b0 || rd_wdata_o !== 32'h0 || dbus_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: rd_we_o=%0b csr_we_o=%0b rd_wdata_o=%08h dbus_addr=%08h want all 0",
               rd_we_o, csr_we_o, rd_wdata_o, dbus_addr);
    end
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    clear_inputs();
    rst_n = 1;
    tick();
  endtask

  task automatic test_passthrough();
    rd_we = 1; rd_addr = 5'd6; rd_wdata = 32'h1234;
    csr_we = 1; csr_waddr = 12'h300; csr_wdata = 32'hAA;
    #1;
    checks++;
    if (rd_wdata_o !== 32'h1234 || rd_we_o !== 1'b1 || rd_addr_o !== 5'd6) begin
      errors++;
      $display("FAIL pass_rd: we=%0b addr=%0d data=%08h want 1 6 00001234", rd_we_o, rd_addr_o, rd_wdata_o);
    end
    checks++;
    if (csr_we_o !== 1'b1 || csr_waddr_o !== 12'h300 || csr_wdata_o !== 32'hAA) begin
      errors++;
      $display("FAIL pass_csr: we=%0b addr=%03h data=%08h want 1 300 000000aa", csr_we_o, csr_waddr_o, csr_wdata_o);
    end
    checks++;
    if (stall_req !== 1'b0 || dbus_req !== 1'b0 || exc_valid !== 1'b0) begin
      errors++;
      $display("FAIL pass_ctl: stall=%0b req=%0b exc=%0b want 0 0 0", stall_req, dbus_req, exc_valid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp, input int gnt_wait);
    int stall_seen;
    logic [31:0] exp_addr;
    stall_seen = 0;
    exp_addr = {addr[31:2], 2'b00};
    mem_re = 1; mem_funct3 = f3; mem_addr = addr;
    rd_we = 1; rd_addr = 5'd9; rd_wdata = addr;
    for (int i = 0; i <= gnt_wait; i++) begin
      dbus_gnt = (i == gnt_wait);
      #1;
      checks++;
      if (dbus_req !== 1'b1 || dbus_addr !== exp_addr || dbus_we !== 1'b0 || rd_we_o !== 1'b0) begin
        errors++;
        $display("FAIL %s_req: req=%0b addr=%08h we=%0b rd_we_o=%0b want 1 %08h 0 0",
                 name, dbus_req, dbus_addr, dbus_we, rd_we_o, exp_addr);
      end
      stall_seen += int'(stall_req);
      tick();
    end
    dbus_gnt = 0;
    #1;
    checks++;
    if (state_dbg !== 3'd2 || dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_wait: state=%0d req=%0b want 2 0", name, state_dbg, dbus_req);
    end
    stall_seen += int'(stall_req);
    dbus_rvalid = 1; dbus_rdata = rdata;
    tick();
    dbus_rvalid = 0; dbus_rdata = '0;
    #1;
    checks++;
    if (rd_wdata_o !== exp) begin
      errors++;
      $display("FAIL %s_data: got %08h want %08h", name, rd_wdata_o, exp);
    end
    checks++;
    if (rd_we_o !== 1'b1 || stall_req !== 1'b0 || state_dbg !== 3'd3) begin
      errors++;
      $display("FAIL %s_done: rd_we_o=%0b stall=%0b state=%0d want 1 0 3", name, rd_we_o, stall_req, state_dbg);
    end
    checks++;
    if (stall_seen != gnt_wait + 2) begin
      errors++;
      $display("FAIL %s_stall: stall cycles %0d want %0d", name, stall_seen, gnt_wait + 2);
    end
    hold_i = 1;
    tick();
    #1;
    checks++;
    if (state_dbg !== 3'd3 || rd_wdata_o !== exp || dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_hold: state=%0d data=%08h req=%0b want 3 %08h 0", name, state_dbg, rd_wdata_o, dbus_req, exp);
    end
    hold_i = 0;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL %s_idle: state=%0d want 0", name, state_dbg);
    end
  endtask

  task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int grants;
    grants = 0;
    mem_we = 1; mem_funct3 = f3; mem_addr = addr; mem_wdata = wdata; dbus_gnt = 1;
    #1;
    checks++;
    if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_addr !== {addr[31:2], 2'b00} || stall_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_req: req=%0b we=%0b addr=%08h stall=%0b want 1 1 %08h 1",
               name, dbus_req, dbus_we, dbus_addr, stall_req, {addr[31:2], 2'b00});
    end
    checks++;
    if (dbus_be !== exp_be) begin
      errors++;
      $display("FAIL %s_be: got %04b want %04b", name, dbus_be, exp_be);
    end
    checks++;
    if (dbus_wdata !== exp_wdata) begin
      errors++;
      $display("FAIL %s_wdata: got %08h want %08h", name, dbus_wdata, exp_wdata);
    end
    grants += int'(dbus_req & dbus_gnt);
    tick();
    #1;
    checks++;
    if (state_dbg !== 3'd3 || dbus_req !== 1'b0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: state=%0d req=%0b stall=%0b want 3 0 0", name, state_dbg, dbus_req, stall_req);
    end
    grants += int'(dbus_req & dbus_gnt);
    tick();
    clear_inputs();
    #1;
    checks++;
    if (grants != 1 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL %s_once: grants=%0d state=%0d want 1 0", name, grants, state_dbg);
    end
  endtask

  task automatic test_misaligned(input string name, input logic is_ld, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [3:0] exp_cause);
    mem_re = is_ld; mem_we = ~is_ld; mem_funct3 = f3; mem_addr = addr;
    rd_we = is_ld; rd_addr = 5'd4;
    #1;
    checks++;
    if (exc_valid !== 1'b1 || exc_cause !== exp_cause || exc_tval !== addr) begin
      errors++;
      $display("FAIL %s_exc: valid=%0b cause=%0d tval=%08h want 1 %0d %08h", name, exc_valid, exc_cause, exc_tval, exp_cause, addr);
    end
    checks++;
    if (dbus_req !== 1'b0 || stall_req !== 1'b0 || rd_we_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctl: req=%0b stall=%0b rd_we_o=%0b want 0 0 0", name, dbus_req, stall_req, rd_we_o);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (state_dbg !== 3'd0 || exc_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: state=%0d exc=%0b want 0 0", name, state_dbg, exc_valid);
    end
  endtask

  task automatic test_flush_req();
    mem_re = 1; mem_funct3 = 3'b010; mem_addr = 32'h700; rd_we = 1;
    #1;
    tick();
    ctrl_flush = 1;
    #1;
    checks++;
    if (state_dbg !== 3'd1 || dbus_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_req_pre: state=%0d req=%0b want 1 1", state_dbg, dbus_req);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (state_dbg !== 3'd0 || dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_post: state=%0d req=%0b want 0 0", state_dbg, dbus_req);
    end
  endtask

  task automatic test_flush_drain();
    mem_re = 1; mem_funct3 = 3'b010; mem_addr = 32'h500; rd_we = 1; rd_addr = 5'd3; dbus_gnt = 1;
    #1;
    checks++;
    if (dbus_req !== 1'b1 || dbus_addr !== 32'h500) begin
      errors++;
      $display("FAIL drain_first: req=%0b addr=%08h want 1 00000500", dbus_req, dbus_addr);
    end
    tick();
    dbus_gnt = 0;
    ctrl_flush = 1;
    tick();
    ctrl_flush = 0;
    mem_addr = 32'h600;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        dbus_rvalid = 1; dbus_rdata = 32'hBAD0BAD0;
      end
      #1;
      checks++;
      if (state_dbg !== 3'd4 || dbus_req !== 1'b0 || stall_req !== 1'b1) begin
        errors++;
        $display("FAIL drain_hold%0d: state=%0d req=%0b stall=%0b want 4 0 1", i, state_dbg, dbus_req, stall_req);
      end
      tick();
    end
    dbus_rvalid = 0; dbus_rdata = '0;
    #1;
    checks++;
    if (state_dbg !== 3'd0 || dbus_req !== 1'b1 || dbus_addr !== 32'h600 || stall_req !== 1'b1) begin
      errors++;
      $display("FAIL drain_exit: state=%0d req=%0b addr=%08h stall=%0b want 0 1 00000600 1",
               state_dbg, dbus_req, dbus_addr, stall_req);
    end
    dbus_gnt = 1;
    tick();
    dbus_gnt = 0;
    dbus_rvalid = 1; dbus_rdata = 32'h600DF00D;
    tick();
    dbus_rvalid = 0; dbus_rdata = '0;
    #1;
    checks++;
    if (state_dbg !== 3'd3 || rd_wdata_o !== 32'h600DF00D) begin
      errors++;
      $display("FAIL drain_second: state=%0d data=%08h want 3 600df00d", state_dbg, rd_wdata_o);
    end
    tick();
    clear_inputs();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_passthrough();
    test_load("lb",  3'b000, 32'h103, 32'h80FF_FFFF, 32'hFFFF_FF80, 2);
    test_load("lbu", 3'b100, 32'h103, 32'h80FF_FFFF, 32'h0000_0080, 2);
    test_load("lb1", 3'b000, 32'h101, 32'h0000_7F00, 32'h0000_007F, 0);
    test_load("lh",  3'b001, 32'h102, 32'h8001_7FFF, 32'hFFFF_8001, 0);
    test_load("lhu", 3'b101, 32'h100, 32'h1234_8765, 32'h0000_8765, 1);
    test_load("lw",  3'b010, 32'h104, 32'hCAFE_BABE, 32'hCAFE_BABE, 0);
    test_store("sh", 3'b001, 32'h202, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
    test_store("sb", 3'b000, 32'h301, 32'h1234_565A, 4'b0010, 32'h5A5A_5A5A);
    test_store("sw", 3'b010, 32'h400, 32'h1122_3344, 4'b1111, 32'h1122_3344);
    test_misaligned("lw_mis", 1'b1, 3'b010, 32'h101, 4'd4);
    test_misaligned("sh_mis", 1'b0, 3'b001, 32'h203, 4'd6);
    test_misaligned("lh_mis", 1'b1, 3'b001, 32'h105, 4'd4);
    test_misaligned("sw_mis", 1'b0, 3'b010, 32'h402, 4'd6);
    test_flush_req();
    test_flush_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
